// File: rtl/song_select_ctrl_if.sv
// -----------------------------------------------------------------------------
// song_select_ctrl_if
//   Bundles the front-panel inputs and the player-facing outputs of
//   song_select_ctrl.
//
//   Signals:
//     button   [2:0]        raw buttons: [0] previous, [1] pause/play, [2] next
//     mode     [NUM_MODES]  mode-switch vector from the mode selector
//     song_num [SONG_W]     selected song index
//     state    [1:0]        00 STOPPED, 01 PLAYING, 10 PAUSED
//     pause                 high while PAUSED
//     restart               one-cycle pulse: player reloads song_num from note 0
//
//   Modports:
//     master  board / stimulus side (drives button and mode)
//     slave   the controller itself
// -----------------------------------------------------------------------------
interface song_select_ctrl_if #(
  parameter int SONG_W    = 2,
  parameter int NUM_MODES = 3
);
  logic [2:0]           button;
  logic [NUM_MODES-1:0] mode;
  logic [SONG_W-1:0]    song_num;
  logic [1:0]           state;
  logic                 pause;
  logic                 restart;

  modport master (
    output button, mode,
    input  song_num, state, pause, restart
  );

  modport slave (
    input  button, mode,
    output song_num, state, pause, restart
  );
endinterface

// File: rtl/song_select_ctrl.sv
// -----------------------------------------------------------------------------
// song_select_ctrl
//   Playback controller for the piano core. Debounces the previous / pause /
//   next buttons, selects one of NUM_SONGS songs with wrap-around, runs a
//   STOPPED / PLAYING / PAUSED state machine and pulses restart whenever the
//   player has to start the selected song from note 0. A change on the mode
//   switches stops playback and returns to song 0.
//
//   Ports:
//     clk   system clock, everything on posedge
//     rst   asynchronous, active-high reset
//     bus   song_select_ctrl_if.slave (button, mode in; song_num, state,
//           pause, restart out -- all outputs registered)
//
//   Optional feature:
//     SONG_SELECT_AUTO_REPEAT_EN  when defined, holding previous or next keeps
//     stepping the song every REPEAT_CYCLES after the initial press. When
//     undefined no repeat logic is built and a held button steps once.
// -----------------------------------------------------------------------------
module song_select_ctrl #(
  parameter int NUM_SONGS       = 3,
  parameter int SONG_W          = 2,
  parameter int NUM_MODES       = 3,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  song_select_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'b00,
    ST_PLAYING = 2'b01,
    ST_PAUSED  = 2'b10
  } state_t;

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int IDX_W = SONG_W + 1;

  // ---------------------------------------------------------------------------
  // Button synchroniser, debouncer and rising-edge event
  // ---------------------------------------------------------------------------
  logic [2:0]        sync1, sync2;
  logic [2:0]        deb;       // debounced levels
  logic [2:0]        deb_d;     // debounced levels, one cycle late
  logic [2:0]        ev;        // registered one-cycle events
  logic [2:0]        rpt_fire;  // auto-repeat requests (0 unless enabled)
  logic [DCNT_W-1:0] cnt [3];
  logic [1:0]        init_cnt;
  logic              init_done;

  // For three cycles after reset the debounced levels simply follow the
  // synchroniser (which needs two cycles to fill). A button held through
  // reset therefore becomes the resting level without producing an event.
  assign init_done = (init_cnt == 2'd3);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_d    <= '0;
      ev       <= '0;
      init_cnt <= '0;
      for (int k = 0; k < 3; k++) cnt[k] <= '0;
    end else begin
      sync1 <= bus.button;
      sync2 <= sync1;
      deb_d <= deb;
      if (!init_done) begin
        init_cnt <= init_cnt + 2'd1;
        deb      <= sync2;
        deb_d    <= sync2;
        ev       <= '0;
        for (int k = 0; k < 3; k++) cnt[k] <= '0;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (sync2[k] != deb[k]) begin
            if (cnt[k] == DCNT_LAST) begin
              deb[k] <= sync2[k];
              cnt[k] <= '0;
            end else begin
              cnt[k] <= cnt[k] + 1'b1;
            end
          end else begin
            cnt[k] <= '0;
          end
        end
        ev <= (deb & ~deb_d) | rpt_fire;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional auto-repeat for previous [0] and next [2]
  // ---------------------------------------------------------------------------
`ifdef SONG_SELECT_AUTO_REPEAT_EN
  localparam int RCNT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

  logic [RCNT_W-1:0] rpt_cnt_prev, rpt_cnt_next;
  logic              both_held, rise_prev, rise_next;
  logic              run_prev, run_next;

  assign both_held = deb[0] & deb[2];
  assign rise_prev = deb[0] & ~deb_d[0];
  assign rise_next = deb[2] & ~deb_d[2];
  // The counter restarts on the press itself so the first repeat lands
  // REPEAT_CYCLES after the initial event; holding both buttons parks it.
  assign run_prev  = init_done & deb[0] & ~both_held & ~rise_prev;
  assign run_next  = init_done & deb[2] & ~both_held & ~rise_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_prev <= '0;
      rpt_cnt_next <= '0;
    end else begin
      if (!run_prev || rpt_cnt_prev == RCNT_LAST) rpt_cnt_prev <= '0;
      else                                        rpt_cnt_prev <= rpt_cnt_prev + 1'b1;
      if (!run_next || rpt_cnt_next == RCNT_LAST) rpt_cnt_next <= '0;
      else                                        rpt_cnt_next <= rpt_cnt_next + 1'b1;
    end
  end

  always_comb begin
    rpt_fire    = '0;
    rpt_fire[0] = run_prev && (rpt_cnt_prev == RCNT_LAST);
    rpt_fire[2] = run_next && (rpt_cnt_next == RCNT_LAST);
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_CYCLES;
  assign rpt_fire          = '0;
`endif

  // ---------------------------------------------------------------------------
  // Mode-change detection
  // ---------------------------------------------------------------------------
  logic [NUM_MODES-1:0] mode_q;
  logic                 mode_chg;

  assign mode_chg = (mode_q != bus.mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= '0;
    else     mode_q <= bus.mode;
  end

  // ---------------------------------------------------------------------------
  // Song index arithmetic (one spare bit so NUM_SONGS = 2^SONG_W is safe)
  // ---------------------------------------------------------------------------
  logic [SONG_W-1:0] song_q, song_inc, song_dec;
  logic [IDX_W-1:0]  idx_wide, idx_plus;

  always_comb begin
    idx_wide = {1'b0, song_q};
    idx_plus = idx_wide + 1'b1;
    song_inc = (idx_plus == IDX_W'(NUM_SONGS)) ? '0 : SONG_W'(idx_plus);
    song_dec = (idx_wide == '0) ? SONG_W'(IDX_W'(NUM_SONGS - 1))
                                : SONG_W'(idx_wide - 1'b1);
  end

  // ---------------------------------------------------------------------------
  // Playback FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t            state_q, state_n;
  logic [SONG_W-1:0] song_n;
  logic              restart_q, restart_n;
  logic              pause_q;
  logic              ev_prev, ev_pause, ev_next;

  assign ev_prev  = ev[0];
  assign ev_pause = ev[1];
  assign ev_next  = ev[2];

  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n   = state_q;
    song_n    = song_q;
    restart_n = 1'b0;
    if (mode_chg) begin
      state_n = ST_STOPPED;
      song_n  = '0;
    end else if (ev_prev ^ ev_next) begin
      song_n    = ev_next ? song_inc : song_dec;
      state_n   = ST_PLAYING;
      restart_n = 1'b1;
    end else if (ev_pause) begin
      unique case (state_q)
        ST_STOPPED: begin
          state_n   = ST_PLAYING;
          restart_n = 1'b1;
        end
        ST_PLAYING: state_n = ST_PAUSED;
        ST_PAUSED:  state_n = ST_PLAYING;  // resume where the player left off
        default:    state_n = ST_STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_STOPPED;
      song_q    <= '0;
      restart_q <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      song_q    <= song_n;
      restart_q <= restart_n;
      pause_q   <= (state_n == ST_PAUSED);
    end
  end

  assign bus.song_num = song_q;
  assign bus.state    = state_q;
  assign bus.pause    = pause_q;
  assign bus.restart  = restart_q;

endmodule

// File: tb/tb_song_select_ctrl.sv
// -----------------------------------------------------------------------------
// tb_song_select_ctrl
//   Scoreboard bench for song_select_ctrl (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20,
//   NUM_SONGS=3). Each press updates a small behavioural model that pushes the
//   expected output word; a monitor pops and compares whenever the DUT's
//   registered outputs change or restart pulses.
// -----------------------------------------------------------------------------
module tb_song_select_ctrl;

  localparam int NUM_SONGS = 3;
  localparam int SONG_W    = 2;
  localparam int NUM_MODES = 3;
  localparam int DEB       = 4;
  localparam int RPT       = 20;

  localparam logic [1:0] S_STOPPED = 2'b00;
  localparam logic [1:0] S_PLAYING = 2'b01;
  localparam logic [1:0] S_PAUSED  = 2'b10;

`ifdef SONG_SELECT_AUTO_REPEAT_EN
  localparam int HOLD_EVENTS = 4;
`else
  localparam int HOLD_EVENTS = 1;
`endif

  typedef struct packed {
    logic [7:0] song;
    logic [1:0] state;
    logic       pause;
    logic       restart;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  song_select_ctrl_if #(.SONG_W(SONG_W), .NUM_MODES(NUM_MODES)) bus ();

  song_select_ctrl #(
    .NUM_SONGS      (NUM_SONGS),
    .SONG_W         (SONG_W),
    .NUM_MODES      (NUM_MODES),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  obs_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         m_song;
  logic [1:0] m_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic void push_exp(input logic rs);
    obs_t e;
    e.song    = 8'(m_song);
    e.state   = m_state;
    e.pause   = (m_state == S_PAUSED);
    e.restart = rs;
    exp_q.push_back(e);
  endfunction

  function automatic void model_step(input logic prv, input logic pse, input logic nxt);
    if (prv ^ nxt) begin
      m_song  = nxt ? (m_song + 1) % NUM_SONGS : (m_song + NUM_SONGS - 1) % NUM_SONGS;
      m_state = S_PLAYING;
      push_exp(1'b1);
    end else if (pse) begin
      case (m_state)
        S_STOPPED: begin m_state = S_PLAYING; push_exp(1'b1); end
        S_PLAYING: begin m_state = S_PAUSED;  push_exp(1'b0); end
        default:   begin m_state = S_PLAYING; push_exp(1'b0); end
      endcase
    end
  endfunction

  function automatic void model_mode_change();
    if (m_song != 0 || m_state != S_STOPPED) begin
      m_song  = 0;
      m_state = S_STOPPED;
      push_exp(1'b0);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Output monitor
  // ---------------------------------------------------------------------------
  initial begin
    obs_t prev, cur, e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur.song    = 8'(bus.song_num);
      cur.state   = bus.state;
      cur.pause   = bus.pause;
      cur.restart = bus.restart;
      if (!rst && (cur.restart || cur.song != prev.song ||
                   cur.state != prev.state || cur.pause != prev.pause)) begin
        if (exp_q.size() == 0) begin
          check("spurious_update_pending", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("output_word", 32'(cur), 32'(e));
        end
      end
      prev = cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    m_song  = 0;
    m_state = S_STOPPED;
    exp_q.delete();
    tick(5);
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    @(negedge clk);
    bus.button = mask;
    model_step(mask[0], mask[1], mask[2]);
    tick(hold);
    bus.button = 3'b000;
    tick(12);
    wait_idle();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int rcount;
    int lat;
    int seq [3];
    seq = '{1, 2, 0};

    rst        = 1'b1;
    bus.button = 3'b000;
    bus.mode   = '0;
    m_song     = 0;
    m_state    = S_STOPPED;
    tick(3);
    rst = 1'b0;

    // Idle after reset
    rcount = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.restart) rcount++;
    end
    check("idle_restart_count", 32'(rcount), 32'd0);
    check("reset_song", 32'(bus.song_num), 32'd0);
    check("reset_state", 32'(bus.state), 32'(S_STOPPED));
    check("reset_pause", 32'(bus.pause), 32'd0);

    // Mode change while already stopped at 0 must not disturb the outputs
    @(negedge clk);
    bus.mode = 3'b001;
    tick(5);

    // Bouncing next button, then a stable press
    for (int i = 0; i < 3; i++) begin
      bus.button = 3'b100;
      tick(2);
      bus.button = 3'b000;
      tick(2);
    end
    bus.button = 3'b100;
    model_step(1'b0, 1'b0, 1'b1);
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (bus.restart && lat < 0) lat = n;
    end
    check("bounce_restart_latency", 32'(lat), 32'd7);
    @(negedge clk);
    bus.button = 3'b000;
    tick(12);
    wait_idle();
    check("bounce_song", 32'(bus.song_num), 32'd1);
    check("bounce_state", 32'(bus.state), 32'(S_PLAYING));

    // Next x3 with wrap, then previous with wrap
    do_reset();
    check("reset2_song", 32'(bus.song_num), 32'd0);
    for (int i = 0; i < 3; i++) begin
      press(3'b100, 10);
      check("next_seq_song", 32'(bus.song_num), 32'(seq[i]));
    end
    press(3'b001, 10);
    check("prev_wrap_song", 32'(bus.song_num), 32'd2);

    // Pause cycle from STOPPED
    do_reset();
    press(3'b010, 10);
    check("pause1_state", 32'(bus.state), 32'(S_PLAYING));
    press(3'b010, 10);
    check("pause2_state", 32'(bus.state), 32'(S_PAUSED));
    check("pause2_pause", 32'(bus.pause), 32'd1);
    press(3'b010, 10);
    check("pause3_state", 32'(bus.state), 32'(S_PLAYING));

    // Paused at index 2, then a mode change
    press(3'b001, 10);
    press(3'b010, 10);
    check("paused_idx2_song", 32'(bus.song_num), 32'd2);
    check("paused_idx2_state", 32'(bus.state), 32'(S_PAUSED));
    @(negedge clk);
    bus.mode = 3'b010;
    model_mode_change();
    tick(5);
    wait_idle();
    check("mode_chg_song", 32'(bus.song_num), 32'd0);
    check("mode_chg_state", 32'(bus.state), 32'(S_STOPPED));
    check("mode_chg_pause", 32'(bus.pause), 32'd0);

    // Previous and next together cancel
    press(3'b101, 10);
    check("cancel_song", 32'(bus.song_num), 32'd0);
    check("cancel_state", 32'(bus.state), 32'(S_STOPPED));

    // Long hold of next: one event, plus repeats when auto-repeat is built
    @(negedge clk);
    bus.button = 3'b100;
    for (int i = 0; i < HOLD_EVENTS; i++) model_step(1'b0, 1'b0, 1'b1);
    tick(70);
    bus.button = 3'b000;
    tick(15);
    wait_idle();
    check("hold_song", 32'(bus.song_num), 32'd1);

    // Reset mid-debounce with next held through release of reset
    @(negedge clk);
    bus.button = 3'b100;
    tick(3);
    rst = 1'b1;
    tick(2);
    rst     = 1'b0;
    m_song  = 0;
    m_state = S_STOPPED;
    exp_q.delete();
    tick(12);
    check("held_reset_song", 32'(bus.song_num), 32'd0);
    check("held_reset_state", 32'(bus.state), 32'(S_STOPPED));
    bus.button = 3'b000;
    tick(12);
    press(3'b100, 10);
    check("after_held_reset_song", 32'(bus.song_num), 32'd1);

    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/song_select_ctrl.md
# song_select_ctrl

Parametrised, fully synchronous playback controller for the piano core. It debounces the three front-panel buttons (previous, pause, next) and selects one of `NUM_SONGS` songs with wrap-around. It runs a stopped/playing/paused state machine and issues a one-cycle restart pulse to the song player whenever playback must restart. It sits between the board I/O and the song ROM/player, and also reacts to mode-switch changes from the mode selector.

## Interface
- `NUM_SONGS`, 3 — number of selectable songs, 2..256.
- `SONG_W`, 2 — width of `song_num`; must satisfy 2^SONG_W ≥ NUM_SONGS.
- `NUM_MODES`, 3 — width of the mode vector.
- `DEBOUNCE_CYCLES`, 200000 — consecutive stable cycles required before a button level is accepted, ≥1.
- `REPEAT_CYCLES`, 25000000 — hold time before and between auto-repeat steps; only used with `AUTO_REPEAT_EN`.

Ports:
- `clk` in 1 — system clock; all logic rises on posedge.
- `rst` in 1 — asynchronous, active-high reset.
- `button` in 3 — raw buttons: [0] previous, [1] pause/play, [2] next; asynchronous, bouncing.
- `mode` in NUM_MODES — mode-switch vector, quasi-static.
- `song_num` out SONG_W — selected song index, 0..NUM_SONGS-1.
- `state` out 2 — 2'b00 STOPPED, 2'b01 PLAYING, 2'b10 PAUSED.
- `pause` out 1 — high exactly when `state` == PAUSED.
- `restart` out 1 — one-cycle pulse; the player reloads `song_num` from note 0.

## Operation
- Each button passes through a 2-flop synchroniser and then a per-button counter.
  - The debounced level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch-free cycle clears the counter.
- A rising edge of a debounced level produces a one-cycle event: `ev_prev`, `ev_pause` or `ev_next`.
- `mode` is registered once. Any difference between the registered and current value in a cycle is a `mode_chg` event.
- Song index:
  - `ev_next`: index+1, wrapping NUM_SONGS-1 → 0.
  - `ev_prev`: index-1, wrapping 0 → NUM_SONGS-1.
  - `ev_next` and `ev_prev` in the same cycle: they cancel, and the index is unchanged.
- FSM, evaluated per cycle in priority order:
  1. `mode_chg`: go to STOPPED and set the index to 0. No `restart`.
  2. A net index change (prev xor next): go to PLAYING and pulse `restart`, from any state.
  3. `ev_pause`:
     - STOPPED → PLAYING, with a `restart` pulse.
     - PLAYING → PAUSED.
     - PAUSED → PLAYING, with no `restart`; the player resumes.
  4. Otherwise hold.
- `ev_pause` arriving in the same cycle as a higher-priority event is dropped.
- Index arithmetic is done in SONG_W+1 bits to avoid overflow at NUM_SONGS = 2^SONG_W.

## Timing
- Reset values:
  - `song_num` = 0, `state` = STOPPED, `pause` = 0, `restart` = 0.
  - Debounced levels = 0, counters = 0.
  - Registered mode = 0.
- The first `mode_chg` after reset fires if `mode` ≠ 0. This is harmless, since the block is already STOPPED at index 0.
- Latency: a raw edge that is stable from cycle t produces an event in cycle t+2+DEBOUNCE_CYCLES.
  - `song_num`, `state`, `pause` and `restart` update on the following edge, which is registered output.
- `restart` is never high for two consecutive cycles from a single press.
- Holding a button produces one event only. Release produces none.
- Reset asserted mid-debounce or mid-pulse clears all state immediately. After release, buttons that are still held are not seen as new presses until they are released and pressed again.
  - This works because the debounced levels reset to 0 and then re-track the held level without an edge event.
  - Implement this with a one-shot post-reset load of the debounced levels from the synchronised inputs.

## Configuration
- `SONG_SELECT_AUTO_REPEAT_EN` defined:
  - Holding previous or next for REPEAT_CYCLES after its event generates an extra event.
  - It then generates another event every REPEAT_CYCLES until release.
  - Each repeat event follows the normal index and `restart` rules.
  - If both buttons are held together, repeats from both are suppressed.
- Not defined:
  - No repeat counter logic is synthesised.
  - A held button yields exactly one event.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20, NUM_SONGS=3.

- Reset, then idle 50 cycles → `song_num`=0, `state`=00, `pause`=0, `restart` never high.
- Bounce `button[2]` high/low every 2 cycles for 12 cycles, then hold high → exactly one `restart` pulse, `song_num`=1, `state`=01. Pulse lands 7 cycles after the stable edge.
- Three next presses from index 0 → `song_num` sequence 1,2,0. Then one previous press → 2, with a `restart` pulse on every change.
- From STOPPED, press pause → PLAYING plus `restart`. Press pause → PAUSED, `pause`=1. Press pause → PLAYING, no `restart`.
- While PAUSED at index 2, change `mode` from 001 to 010 → `state`=00, `song_num`=0, `pause`=0, no `restart`. Next and previous pressed in the same cycle → no change.
- With the macro defined, hold next for 70 cycles → 1 initial event plus 3 repeat events, giving `song_num` 1,2,0,1. Without the macro → `song_num`=1 only.
